// File: rtl/card_shoe_dealer_pkg.sv
// Shared types and constants for the card shoe dealer: card encoding, rank
// limits, deck size and the dealer FSM state type.
package card_shoe_dealer_pkg;

  typedef logic [3:0] card_t;

  localparam card_t NO_CARD   = 4'd0;
  localparam card_t RANK_ACE  = 4'd1;
  localparam card_t RANK_KING = 4'd13;

  localparam int RANKS          = 13;
  localparam int CARDS_PER_DECK = 52;

  typedef enum logic {IDLE, SEARCH} shoe_state_t;

  // Successor in the cyclic rank order A,2..10,J,Q,K,A,...
  function automatic card_t next_rank(input card_t r);
    return (r == RANK_KING) ? RANK_ACE : card_t'(r + 4'd1);
  endfunction

endpackage

// File: rtl/card_shoe_dealer_if.sv
// Request/response bundle between the game FSM (master) and the shoe dealer
// (slave); also fans the dealt card out to the datapath card registers.
interface card_shoe_dealer_if
  import card_shoe_dealer_pkg::*;
#(
  parameter int DECKS = 1
);
  localparam int CW = $clog2(CARDS_PER_DECK * DECKS + 1);

  logic          deal_req;
  logic          reshuffle;
  card_t         new_card;
  logic          card_valid;
  logic          busy;
  logic          deal_err;
  logic          shoe_empty;
  logic [CW-1:0] cards_left;

  modport master (
    output deal_req, reshuffle,
    input  new_card, card_valid, busy, deal_err, shoe_empty, cards_left
  );

  modport slave (
    input  deal_req, reshuffle,
    output new_card, card_valid, busy, deal_err, shoe_empty, cards_left
  );

endinterface

// File: rtl/card_shoe_dealer_rank_ticker.sv
// Free-running rank ticker: cycles 1..13 every clock, never shows 0, 14 or 15.
module rank_ticker
  import card_shoe_dealer_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  output card_t rank
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, whatever the order of always blocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rank <= RANK_ACE;
    else       rank <= next_rank(rank);
  end

endmodule

// File: rtl/card_shoe_dealer.sv
// Finite-shoe card source: samples the rank ticker on a deal request and walks
// forward past exhausted ranks until it finds one with cards remaining.
module card_shoe_dealer
  import card_shoe_dealer_pkg::*;
#(
  parameter int DECKS = 1
)(
  input  logic                 clock,
  input  logic                 reset,
  card_shoe_dealer_if.slave    bus
);

  localparam int CW        = $clog2(CARDS_PER_DECK * DECKS + 1);
  localparam int CNT_W     = $clog2(4 * DECKS + 1);
  localparam logic [CW-1:0]    FULL_SHOE = CW'(CARDS_PER_DECK * DECKS);
  localparam logic [CNT_W-1:0] FULL_RANK = CNT_W'(4 * DECKS);

  shoe_state_t      state;
  card_t            ticker;
  card_t            probe;
  card_t            new_card;
  logic             card_valid;
  logic             busy;
  logic             deal_err;
  logic [CW-1:0]    cards_left;
  logic [CNT_W-1:0] rank_cnt [1:RANKS];

  rank_ticker u_ticker (
    .clock (clock),
    .reset (reset),
    .rank  (ticker)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      probe      <= RANK_ACE;
      new_card   <= NO_CARD;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      deal_err   <= 1'b0;
      cards_left <= FULL_SHOE;
      // NOTE: the count array is reset on purpose: a freshly reset shoe must
      // be full, so these are flops with a reset value, not a RAM.
      for (int r = 1; r <= RANKS; r++) rank_cnt[r] <= FULL_RANK;
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      if (bus.reshuffle) begin
        // Reshuffle beats everything, including an in-flight search.
        state      <= IDLE;
        new_card   <= NO_CARD;
        busy       <= 1'b0;
        cards_left <= FULL_SHOE;
        for (int r = 1; r <= RANKS; r++) rank_cnt[r] <= FULL_RANK;
      end else begin
        case (state)
          IDLE: begin
            if (bus.deal_req) begin
              if (cards_left == '0) begin
                deal_err <= 1'b1;
              end else begin
                probe <= ticker;
                busy  <= 1'b1;
                state <= SEARCH;
              end
            end
          end
          SEARCH: begin
            // Terminates: SEARCH is only entered with at least one card left.
            if (rank_cnt[probe] != '0) begin
              rank_cnt[probe] <= rank_cnt[probe] - 1'b1;
              cards_left      <= cards_left - 1'b1;
              new_card        <= probe;
              card_valid      <= 1'b1;
              busy            <= 1'b0;
              state           <= IDLE;
            end else begin
              probe <= next_rank(probe);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.new_card   = new_card;
  assign bus.card_valid = card_valid;
  assign bus.busy       = busy;
  assign bus.deal_err   = deal_err;
  assign bus.cards_left = cards_left;
  assign bus.shoe_empty = (cards_left == '0);

endmodule
